// File: rtl/occupancy_count_writer_if.sv
// Port-B write bus between the occupancy counter (master) and the memory arbiter (slave).
interface occupancy_count_writer_if;
  logic [15:0] memAddr;
  logic [15:0] memDataW;
  logic        memWe;
  logic        memGrant;

  modport master (output memAddr, output memDataW, output memWe, input memGrant);
  modport slave  (input memAddr, input memDataW, input memWe, output memGrant);
endinterface

// File: rtl/occupancy_count_writer.sv
// Debounces two beam sensors, decodes walk direction, keeps a saturating occupancy count
// and writes it to memory port B during vertical blank when the arbiter grants.
module occupancy_count_writer #(
  parameter logic [15:0] COUNT_ADDR      = 16'h1000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] MAX_COUNT       = 16'd9999,
  parameter logic [15:0] INIT_COUNT      = 16'd0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sensA,
  input  logic                            sensB,
  input  logic                            vBlank,
  occupancy_count_writer_if.master        mem,
  output logic [15:0]                     count,
  output logic                            dirty
);

  typedef enum logic [2:0] {
    S_IDLE, S_A1, S_AB, S_ABB, S_B1, S_BA, S_BAA, S_WAIT_CLR
  } state_t;

  logic [1:0] raw;
  logic [1:0] deb;
  assign raw = {sensB, sensA};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_sens
      logic        sync1_reg;
      logic        sync2_reg;
      logic        deb_reg;
      logic [15:0] cnt_reg;

      // Counter only runs while the synchronized level disagrees with the debounced one.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          cnt_reg   <= 16'd0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= 16'd0;
          end else if (cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
            deb_reg <= ~deb_reg;
            cnt_reg <= 16'd0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      end

      assign deb[gi] = deb_reg;
    end
  endgenerate

  logic [1:0] pair;
  assign pair = {deb[0], deb[1]};

  state_t state_reg, state_next;
  logic   inc, dec;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     case (pair)
                    2'b10: state_next = S_A1;
                    2'b01: state_next = S_B1;
                    2'b11: state_next = S_WAIT_CLR;
                    default: ;
                  endcase
      S_A1:       case (pair)
                    2'b11: state_next = S_AB;
                    2'b00: state_next = S_IDLE;
                    2'b01: state_next = S_WAIT_CLR;
                    default: ;
                  endcase
      S_AB:       case (pair)
                    2'b01: state_next = S_ABB;
                    2'b10: state_next = S_A1;
                    2'b00: state_next = S_IDLE;
                    default: ;
                  endcase
      S_ABB:      case (pair)
                    2'b00: state_next = S_IDLE;
                    2'b11: state_next = S_AB;
                    2'b10: state_next = S_WAIT_CLR;
                    default: ;
                  endcase
      S_B1:       case (pair)
                    2'b11: state_next = S_BA;
                    2'b00: state_next = S_IDLE;
                    2'b10: state_next = S_WAIT_CLR;
                    default: ;
                  endcase
      S_BA:       case (pair)
                    2'b10: state_next = S_BAA;
                    2'b01: state_next = S_B1;
                    2'b00: state_next = S_IDLE;
                    default: ;
                  endcase
      S_BAA:      case (pair)
                    2'b00: state_next = S_IDLE;
                    2'b11: state_next = S_BA;
                    2'b01: state_next = S_WAIT_CLR;
                    default: ;
                  endcase
      S_WAIT_CLR: if (pair == 2'b00) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // A completed walk is recognised on the edge that returns the FSM to IDLE.
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    if (pair == 2'b00) begin
      inc = (state_reg == S_ABB);
      dec = (state_reg == S_BAA);
    end
  end

  logic [15:0] count_reg;
  logic [15:0] data_reg;
  logic        dirty_reg;
  logic        we_reg;
  logic        inc_ok, dec_ok, write_ok;

  assign inc_ok   = inc && (count_reg != MAX_COUNT);
  assign dec_ok   = dec && (count_reg != 16'd0);
  assign write_ok = dirty_reg && vBlank && mem.memGrant;

  // A write coinciding with a count change carries the old value and leaves dirty set.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= INIT_COUNT;
      dirty_reg <= 1'b1;
      we_reg    <= 1'b0;
      data_reg  <= 16'd0;
    end else begin
      if (inc_ok)      count_reg <= count_reg + 16'd1;
      else if (dec_ok) count_reg <= count_reg - 16'd1;
      we_reg <= write_ok;
      if (write_ok) data_reg <= count_reg;
      if (inc_ok || dec_ok) dirty_reg <= 1'b1;
      else if (write_ok)    dirty_reg <= 1'b0;
    end
  end

  assign count        = count_reg;
  assign dirty        = dirty_reg;
  assign mem.memWe    = we_reg;
  assign mem.memDataW = data_reg;
  assign mem.memAddr  = COUNT_ADDR;

endmodule

// File: tb/tb_occupancy_count_writer.sv
// Randomized and directed bench for occupancy_count_writer; two instances share stimulus,
// one starting near the saturation ceiling.
module tb_occupancy_count_writer;
  localparam int DB  = 4;
  localparam int MAX = 9999;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensA = 1'b0;
  logic sensB = 1'b0;
  logic vBlank = 1'b0;
  logic grant = 1'b0;

  occupancy_count_writer_if mem0();
  occupancy_count_writer_if mem1();
  assign mem0.memGrant = grant;
  assign mem1.memGrant = grant;

  logic [15:0] count0, count1;
  logic        dirty0, dirty1;

  occupancy_count_writer #(.DEBOUNCE_CYCLES(16'd4)) dut0 (
    .clk(clk), .reset(reset), .sensA(sensA), .sensB(sensB), .vBlank(vBlank),
    .mem(mem0), .count(count0), .dirty(dirty0));

  occupancy_count_writer #(.DEBOUNCE_CYCLES(16'd4), .INIT_COUNT(16'd9998)) dut1 (
    .clk(clk), .reset(reset), .sensA(sensA), .sensB(sensB), .vBlank(vBlank),
    .mem(mem1), .count(count1), .dirty(dirty1));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_A1 = 1, M_AB = 2, M_ABB = 3,
                 M_B1 = 4, M_BA = 5, M_BAA = 6, M_WAIT = 7;

  bit hist_a[DB+2];
  bit hist_b[DB+2];
  bit m_deb_a, m_deb_b;
  int m_state;
  int m_cnt[2];
  bit m_dirty[2];
  bit m_we[2];
  int m_data[2];
  int cyc = 0;
  int last_rise_a = -1;
  bit deb_a_seen = 0;
  int pulses0 = 0, pulses1 = 0;

  function automatic int init_of(input int i);
    return (i == 0) ? 0 : 9998;
  endfunction

  // Walk-direction table: each row lists the pairs that move the state.
  function automatic void walk_step(input int s, input bit a, input bit b,
                                    output int ns, output bit inc, output bit dec);
    int p;
    p = {a, b};
    ns = s; inc = 0; dec = 0;
    case (s)
      M_IDLE: if (p == 2) ns = M_A1; else if (p == 1) ns = M_B1; else if (p == 3) ns = M_WAIT;
      M_A1:   if (p == 3) ns = M_AB; else if (p == 0) ns = M_IDLE; else if (p == 1) ns = M_WAIT;
      M_AB:   if (p == 1) ns = M_ABB; else if (p == 2) ns = M_A1; else if (p == 0) ns = M_IDLE;
      M_ABB:  if (p == 0) begin ns = M_IDLE; inc = 1; end
              else if (p == 3) ns = M_AB; else if (p == 2) ns = M_WAIT;
      M_B1:   if (p == 3) ns = M_BA; else if (p == 0) ns = M_IDLE; else if (p == 2) ns = M_WAIT;
      M_BA:   if (p == 2) ns = M_BAA; else if (p == 1) ns = M_B1; else if (p == 0) ns = M_IDLE;
      M_BAA:  if (p == 0) begin ns = M_IDLE; dec = 1; end
              else if (p == 3) ns = M_BA; else if (p == 1) ns = M_WAIT;
      default: if (p == 0) ns = M_IDLE;
    endcase
  endfunction

  task automatic model_step();
    int  ns;
    bit  inc, dec, qual, chg, all_a, all_b, prev_a;
    int  old;
    prev_a = m_deb_a;
    if (reset) begin
      for (int k = 0; k < DB + 2; k++) begin hist_a[k] = 0; hist_b[k] = 0; end
      m_deb_a = 0; m_deb_b = 0; m_state = M_IDLE;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = init_of(i); m_dirty[i] = 1; m_we[i] = 0; m_data[i] = 0;
      end
    end else begin
      walk_step(m_state, m_deb_a, m_deb_b, ns, inc, dec);
      m_state = ns;
      for (int i = 0; i < 2; i++) begin
        old  = m_cnt[i];
        qual = m_dirty[i] && vBlank && grant;
        chg  = 0;
        if (inc && old < MAX) begin m_cnt[i] = old + 1; chg = 1; end
        else if (dec && old > 0) begin m_cnt[i] = old - 1; chg = 1; end
        m_we[i] = qual;
        if (qual) m_data[i] = old;
        if (chg) m_dirty[i] = 1;
        else if (qual) m_dirty[i] = 0;
      end
      // Debounced level follows the synchronized input once it has held for DB edges.
      for (int k = DB + 1; k > 0; k--) begin hist_a[k] = hist_a[k-1]; hist_b[k] = hist_b[k-1]; end
      hist_a[0] = sensA;
      hist_b[0] = sensB;
      all_a = 1; all_b = 1;
      for (int k = 3; k < DB + 2; k++) begin
        if (hist_a[k] != hist_a[2]) all_a = 0;
        if (hist_b[k] != hist_b[2]) all_b = 0;
      end
      if (all_a) m_deb_a = hist_a[2];
      if (all_b) m_deb_b = hist_b[2];
    end
    cyc++;
    if (!prev_a && m_deb_a) last_rise_a = cyc;
    if (m_deb_a) deb_a_seen = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("count0", count0, m_cnt[0]);
      chk("dirty0", dirty0, m_dirty[0]);
      chk("we0", mem0.memWe, m_we[0]);
      chk("addr0", mem0.memAddr, 32'h1000);
      if (m_we[0]) chk("data0", mem0.memDataW, m_data[0]);
      chk("count1", count1, m_cnt[1]);
      chk("dirty1", dirty1, m_dirty[1]);
      chk("we1", mem1.memWe, m_we[1]);
      chk("addr1", mem1.memAddr, 32'h1000);
      if (m_we[1]) chk("data1", mem1.memDataW, m_data[1]);
      pulses0 += int'(mem0.memWe);
      pulses1 += int'(mem1.memWe);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pair(input bit a, input bit b, input int hold);
    sensA = a; sensB = b;
    tick(hold);
  endtask

  task automatic walk_in();
    set_pair(1, 0, 10); set_pair(1, 1, 10); set_pair(0, 1, 10); set_pair(0, 0, 10);
  endtask

  task automatic walk_out();
    set_pair(0, 1, 10); set_pair(1, 1, 10); set_pair(1, 0, 10); set_pair(0, 0, 10);
  endtask

  task automatic wait_we0(input string name, input int lim);
    bit seen;
    seen = 0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(posedge clk); #2;
      if (mem0.memWe) seen = 1;
    end
    chk(name, seen, 1);
  endtask

  initial begin
    int p0, p1, mark;
    tick(3);
    reset = 0; vBlank = 1; grant = 1;

    // T1: initial forced write of the reset value
    wait_we0("t1_pulse", 5);
    chk("t1_data", mem0.memDataW, 0);
    chk("t1_addr", mem0.memAddr, 32'h1000);
    tick(3);
    chk("t1_dirty_clear", dirty0, 0);
    chk("t1_single_pulse", pulses0, 1);

    // T2: entry outside vertical blank, then flush
    vBlank = 0;
    p0 = pulses0;
    walk_in();
    chk("t2_count", count0, 1);
    chk("t2_dirty", dirty0, 1);
    chk("t2_no_write", pulses0 - p0, 0);
    chk("t2_sat_count", count1, 9999);
    vBlank = 1;
    wait_we0("t2_pulse", 5);
    chk("t2_data", mem0.memDataW, 1);

    // T3: exit, aborted walk, decrement at zero
    walk_out();
    chk("t3_exit", count0, 0);
    set_pair(1, 0, 10); set_pair(1, 1, 10); set_pair(1, 0, 10); set_pair(0, 0, 10);
    chk("t3_abort", count0, 0);
    tick(3);
    p0 = pulses0;
    walk_out();
    chk("t3_dec_zero", count0, 0);
    chk("t3_dec_zero_no_write", pulses0 - p0, 0);
    chk("t3_sat_count", count1, 9997);

    // T4: glitch rejection and debounce latency
    deb_a_seen = 0;
    p0 = pulses0;
    sensA = 1; tick(3); sensA = 0; tick(12);
    chk("t4_glitch_deb", deb_a_seen, 0);
    chk("t4_glitch_count", count0, 0);
    chk("t4_glitch_no_write", pulses0 - p0, 0);
    mark = cyc;
    sensA = 1; tick(7); sensA = 0; tick(12);
    chk("t4_latency", last_rise_a - mark, 6);

    // T5: arbitration holds the write until grant
    vBlank = 0;
    walk_in();
    vBlank = 1; grant = 0;
    p0 = pulses0;
    tick(20);
    chk("t5_no_grant", pulses0 - p0, 0);
    chk("t5_dirty_held", dirty0, 1);
    grant = 1;
    @(posedge clk); #2;
    chk("t5_pulse", mem0.memWe, 1);
    chk("t5_data", mem0.memDataW, 1);

    // T6: increment coinciding with a qualifying write
    tick(2);
    vBlank = 0;
    walk_in();
    chk("t6_pre_count", count0, 2);
    set_pair(1, 0, 10); set_pair(1, 1, 10); set_pair(0, 1, 10);
    sensA = 0; sensB = 0;
    tick(6);
    vBlank = 1;
    @(posedge clk); #2;
    chk("t6_we_old", mem0.memWe, 1);
    chk("t6_data_old", mem0.memDataW, 2);
    chk("t6_dirty_kept", dirty0, 1);
    chk("t6_count_new", count0, 3);
    @(posedge clk); #2;
    chk("t6_we_new", mem0.memWe, 1);
    chk("t6_data_new", mem0.memDataW, 3);
    @(posedge clk); #2;
    chk("t6_dirty_clear", dirty0, 0);
    chk("t6_sat_count", count1, 9999);
    tick(3);
    p1 = pulses1;
    walk_in();
    chk("t6_sat_hold", count1, 9999);
    chk("t6_sat_no_write", pulses1 - p1, 0);
    chk("t6_main_count", count0, 4);

    // Randomized walks, glitches, blanking and grant, with one mid-walk reset
    for (int it = 0; it < 60; it++) begin
      vBlank = 1'($urandom_range(0, 1));
      grant  = ($urandom_range(0, 3) != 0);
      if (it == 30) begin
        reset = 1; tick(2); reset = 0;
      end
      set_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    vBlank = 1; grant = 1;
    set_pair(0, 0, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
